// File: rtl/vga_timing_ctrl.sv
// VGA pixel-timing core: pixel divider, H/V counters, frame-buffer address,
// and a two-stage registered sync/RGB pipeline aligned to the frame-buffer read latency.
module vga_timing_ctrl #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned PIX_DIV   = 1,
   parameter int unsigned SCALE_SH  = 0,
   parameter int unsigned AW        = 19
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    fb_data,
   output logic [AW-1:0] fb_addr,
   output logic          fb_rd,
   output logic [9:0]    countX,
   output logic [9:0]    countY,
   output logic          frame_start,
   output logic          VGA_Hsync_n,
   output logic          VGA_Vsync_n,
   output logic          VGA_R,
   output logic          VGA_G,
   output logic          VGA_B
);

   localparam int unsigned CW       = 10;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_FIRST = H_VISIBLE + H_FP;
   localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
   localparam int unsigned VS_FIRST = V_VISIBLE + V_FP;
   localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
   localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int unsigned LINE_W   = H_VISIBLE >> SCALE_SH;

   logic [DIV_W-1:0] div_q, div_d;
   logic [CW-1:0]    cnt_x_q, cnt_x_d;
   logic [CW-1:0]    cnt_y_q, cnt_y_d;
   logic             frame_start_q, frame_start_d;
   logic             hs_s1_q, hs_s1_d;
   logic             vs_s1_q, vs_s1_d;
   logic             von_s1_q, von_s1_d;
   logic             hsync_n_q, hsync_n_d;
   logic             vsync_n_q, vsync_n_d;
   logic [2:0]       rgb_q, rgb_d;

   logic             pix_en;
   logic             x_last;
   logic             y_last;
   logic             hs;
   logic             vs;
   logic             von;
   logic [AW-1:0]    addr_lin;

   // Stage-0 decode straight off the counters
   always_comb begin
      pix_en   = (div_q == DIV_W'(PIX_DIV - 1));
      x_last   = (cnt_x_q == CW'(H_TOTAL - 1));
      y_last   = (cnt_y_q == CW'(V_TOTAL - 1));
      hs       = (cnt_x_q >= CW'(HS_FIRST)) && (cnt_x_q <= CW'(HS_LAST));
      vs       = (cnt_y_q >= CW'(VS_FIRST)) && (cnt_y_q <= CW'(VS_LAST));
      von      = (cnt_x_q < CW'(H_VISIBLE)) && (cnt_y_q < CW'(V_VISIBLE));
      addr_lin = AW'(cnt_y_q >> SCALE_SH) * AW'(LINE_W) + AW'(cnt_x_q >> SCALE_SH);
   end

   // Next-state: everything except the divider and frame_start holds between pixel ticks
   always_comb begin
      div_d         = div_q + DIV_W'(1);
      cnt_x_d       = cnt_x_q;
      cnt_y_d       = cnt_y_q;
      frame_start_d = 1'b0;
      hs_s1_d       = hs_s1_q;
      vs_s1_d       = vs_s1_q;
      von_s1_d      = von_s1_q;
      hsync_n_d     = hsync_n_q;
      vsync_n_d     = vsync_n_q;
      rgb_d         = rgb_q;

      if (pix_en) begin
         div_d = '0;
         if (x_last) begin
            cnt_x_d = '0;
            cnt_y_d = y_last ? '0 : cnt_y_q + CW'(1);
         end else begin
            cnt_x_d = cnt_x_q + CW'(1);
         end
         frame_start_d = x_last && y_last;

         hs_s1_d   = hs;
         vs_s1_d   = vs;
         von_s1_d  = von;

         // fb_data returned now belongs to the pixel decoded one tick ago
         hsync_n_d = ~hs_s1_q;
         vsync_n_d = ~vs_s1_q;
         rgb_d     = von_s1_q ? fb_data : 3'b000;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q         <= '0;
         cnt_x_q       <= '0;
         cnt_y_q       <= '0;
         frame_start_q <= 1'b0;
         hs_s1_q       <= 1'b0;
         vs_s1_q       <= 1'b0;
         von_s1_q      <= 1'b0;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         rgb_q         <= 3'b000;
      end else begin
         div_q         <= div_d;
         cnt_x_q       <= cnt_x_d;
         cnt_y_q       <= cnt_y_d;
         frame_start_q <= frame_start_d;
         hs_s1_q       <= hs_s1_d;
         vs_s1_q       <= vs_s1_d;
         von_s1_q      <= von_s1_d;
         hsync_n_q     <= hsync_n_d;
         vsync_n_q     <= vsync_n_d;
         rgb_q         <= rgb_d;
      end
   end

   // Read strobe is held off while reset is asserted even though (0,0) is visible
   assign fb_rd       = rst & von & pix_en;
   assign fb_addr     = von ? addr_lin : '0;
   assign countX      = cnt_x_q;
   assign countY      = cnt_y_q;
   assign frame_start = frame_start_q;
   assign VGA_Hsync_n = hsync_n_q;
   assign VGA_Vsync_n = vsync_n_q;
   assign {VGA_R, VGA_G, VGA_B} = rgb_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full horizontal timing with a shortened vertical frame,
// plus a second instance exercising the pixel divider and address downscale.
module tb_vga_timing_ctrl;

   localparam int VV = 6;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int VT = VV + VFP + VSY + VBP;
   localparam int HT = 800;
   localparam int FRAME = HT * VT;
   localparam int NT = 14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [2:0]  fb_data0 = 3'b111;
   logic [18:0] fb_addr0;
   logic        fb_rd0, fs0, hs_n0, vs_n0, r0, g0, b0;
   logic [9:0]  cx0, cy0;

   logic [2:0]  fb_data1 = 3'b000;
   logic [18:0] fb_addr1;
   logic        fb_rd1, fs1, hs_n1, vs_n1, r1, g1, b1;
   logic [9:0]  cx1, cy1;

   vga_timing_ctrl #(.V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut0 (
      .clk(clk), .rst(rst), .fb_data(fb_data0), .fb_addr(fb_addr0), .fb_rd(fb_rd0),
      .countX(cx0), .countY(cy0), .frame_start(fs0), .VGA_Hsync_n(hs_n0),
      .VGA_Vsync_n(vs_n0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0));

   vga_timing_ctrl #(.V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                     .PIX_DIV(2), .SCALE_SH(1)) dut1 (
      .clk(clk), .rst(rst), .fb_data(fb_data1), .fb_addr(fb_addr1), .fb_rd(fb_rd1),
      .countX(cx1), .countY(cy1), .frame_start(fs1), .VGA_Hsync_n(hs_n1),
      .VGA_Vsync_n(vs_n1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1));

   always #5 clk = ~clk;

   // Model frame buffer: returns addr[2:0] one tick after a read, 111 otherwise
   always @(posedge clk) fb_data0 <= fb_rd0 ? fb_addr0[2:0] : 3'b111;

   typedef struct packed {
      logic       hs_n;
      logic       vs_n;
      logic [2:0] rgb;
   } pins_t;

   typedef struct {
      int   k;
      int   x;
      int   y;
      logic hs_n;
      logic vs_n;
      logic fs;
   } vec_t;

   vec_t  tbl [NT];
   pins_t sb_q[$];
   int    checks = 0;
   int    errors = 0;
   int    hs_first, hs_low, vs_first, vs_low, fs_cnt;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic pins_t exp_pins(input int x, input int y);
      pins_t p;
      logic  von;
      von    = (x < 640) && (y < VV);
      p.hs_n = !((x >= 656) && (x <= 751));
      p.vs_n = !((y >= VV + VFP) && (y <= VV + VFP + VSY - 1));
      p.rgb  = von ? 3'(x & 7) : 3'b000;
      return p;
   endfunction

   task automatic seed_sb();
      sb_q.delete();
      sb_q.push_back(pins_t'({1'b1, 1'b1, 3'b000}));
      sb_q.push_back(exp_pins(0, 0));
   endtask

   // Sampled at the negedge following active edge k after reset release
   task automatic check_cycle(input int k);
      int    x, y, c1, x1, y1;
      logic  von, von1;
      pins_t e, got;
      x   = k % HT;
      y   = (k / HT) % VT;
      von = (x < 640) && (y < VV);
      chk("countX", 32'(cx0), x);
      chk("countY", 32'(cy0), y);
      chk("fb_rd", 32'(fb_rd0), 32'(von));
      chk("fb_addr", 32'(fb_addr0), von ? y * 640 + x : 0);
      chk("frame_start", 32'(fs0), 32'(k > 0 && x == 0 && y == 0));
      got = {hs_n0, vs_n0, r0, g0, b0};
      if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
         e = sb_q.pop_front();
         chk("pins", 32'(got), 32'(e));
      end
      sb_q.push_back(exp_pins(x, y));

      for (int i = 0; i < NT; i++) begin
         if (tbl[i].k == k) begin
            chk("tbl_x", 32'(cx0), tbl[i].x);
            chk("tbl_y", 32'(cy0), tbl[i].y);
            chk("tbl_hs_n", 32'(hs_n0), 32'(tbl[i].hs_n));
            chk("tbl_vs_n", 32'(vs_n0), 32'(tbl[i].vs_n));
            chk("tbl_fs", 32'(fs0), 32'(tbl[i].fs));
         end
      end

      c1   = k / 2;
      x1   = c1 % HT;
      y1   = (c1 / HT) % VT;
      von1 = (x1 < 640) && (y1 < VV);
      chk("div_countX", 32'(cx1), x1);
      chk("div_countY", 32'(cy1), y1);
      chk("div_fb_addr", 32'(fb_addr1), von1 ? (y1 >> 1) * 320 + (x1 >> 1) : 0);
      chk("div_fb_rd", 32'(fb_rd1), 32'(von1 && (k % 2 == 1)));
      chk("div_frame_start", 32'(fs1), 32'((k % 2 == 0) && c1 > 0 && x1 == 0 && y1 == 0));
      if (k == 4811) begin
         chk("div_addr_5_3", 32'(fb_addr1), 322);
         chk("div_rd_5_3", 32'(fb_rd1), 1);
      end
      if (k == 1599) chk("div_line_end_x", 32'(cx1), 799);
      if (k == 1600) chk("div_line_y", 32'(cy1), 1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_countX"}, 32'(cx0), 0);
      chk({tag, "_countY"}, 32'(cy0), 0);
      chk({tag, "_hs_n"}, 32'(hs_n0), 1);
      chk({tag, "_vs_n"}, 32'(vs_n0), 1);
      chk({tag, "_rgb"}, 32'({r0, g0, b0}), 0);
      chk({tag, "_fb_rd"}, 32'(fb_rd0), 0);
      chk({tag, "_frame_start"}, 32'(fs0), 0);
      chk({tag, "_div_countX"}, 32'(cx1), 0);
      chk({tag, "_div_countY"}, 32'(cy1), 0);
      chk({tag, "_div_fb_rd"}, 32'(fb_rd1), 0);
   endtask

   initial begin
      tbl[0]  = '{1,     1,   0, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{657,   657, 0, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{658,   658, 0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{753,   753, 0, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{754,   754, 0, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{799,   799, 0, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{800,   0,   1, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{6401,  1,   8, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{6402,  2,   8, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{8001,  1,  10, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{8002,  2,  10, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{10399, 799, 12, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{10400, 0,   0, 1'b1, 1'b1, 1'b1};
      tbl[13] = '{10401, 1,   0, 1'b1, 1'b1, 1'b0};

      #1 rst = 1'b0;
      repeat (50) @(negedge clk);
      check_reset_vals("rst_hold");

      hs_first = -1; hs_low = 0; vs_first = -1; vs_low = 0; fs_cnt = 0;
      seed_sb();
      rst = 1'b1;
      for (int k = 1; k <= FRAME + 3100; k++) begin
         @(negedge clk);
         check_cycle(k);
         if (k <= HT && !hs_n0) begin
            hs_low++;
            if (hs_first < 0) hs_first = k;
         end
         if (k <= FRAME) begin
            if (!vs_n0) begin
               vs_low++;
               if (vs_first < 0) vs_first = k;
            end
            if (fs0) fs_cnt++;
         end
      end
      chk("hs_fall_clk", hs_first, 658);
      chk("hs_low_width", hs_low, 96);
      chk("vs_fall_clk", vs_first, (VV + VFP) * HT + 2);
      chk("vs_low_width", vs_low, 1600);
      chk("frame_start_count", fs_cnt, 1);

      // Counters now at (700,3) with hsync low on the pins; reset must clear at once
      chk("pre_rst_hs_n", 32'(hs_n0), 0);
      #2 rst = 1'b0;
      #1 check_reset_vals("mid_rst");
      repeat (5) @(negedge clk);
      check_reset_vals("mid_rst_hold");

      seed_sb();
      rst = 1'b1;
      for (int k = 1; k <= FRAME + 2; k++) begin
         @(negedge clk);
         check_cycle(k);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
